// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides the system clock to quarter-frame ticks and
// walks an NES-style 4-step or 5-step sequence. It emits one-cycle
// quarter_frame/half_frame strobes, registered one cycle after the tick.
// Optional feature macro: FRAME_IRQ_EN enables the frame IRQ flag, the
// inhibit bit and irq_ack. Without it, frame_irq is tied low.
module apu_frame_sequencer #(
    parameter int CLKRATE   = 3_579_545,
    parameter int FRAMERATE = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic       cfg_mode,
    input  logic       cfg_irq_inhibit,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic [2:0] step
);

    localparam int DIV   = CLKRATE / FRAMERATE;
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2) begin : g_div_check
            $error("apu_frame_sequencer: CLKRATE/FRAMERATE must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        STEP_0 = 3'd0,
        STEP_1 = 3'd1,
        STEP_2 = 3'd2,
        STEP_3 = 3'd3,
        STEP_4 = 3'd4
    } step_t;

    step_t            step_q, step_d;
    logic [CNT_W-1:0] div_cnt_q;
    logic             mode_q;
    logic             tick;
    logic             q_d, h_d;
    logic             set_irq;

    assign tick = (div_cnt_q == CNT_W'(DIV - 1));
    assign step = step_q;

    // Divider: free-running 0..DIV-1, restarted by a config write
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else if (cfg_we || tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + CNT_W'(1);
        end
    end

    // Sequence mode register, loaded on a config write
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (cfg_we) begin
            mode_q <= cfg_mode;
        end
    end

    // Step sequencer state register and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q        <= STEP_0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            step_q        <= step_d;
            quarter_frame <= q_d;
            half_frame    <= h_d;
        end
    end

    // Next step and strobe decode; a config write overrides a coincident tick
    always_comb begin
        step_d  = step_q;
        q_d     = 1'b0;
        h_d     = 1'b0;
        set_irq = 1'b0;
        if (cfg_we) begin
            // 5-step mode clocks the units immediately on the write
            step_d = STEP_0;
            q_d    = cfg_mode;
            h_d    = cfg_mode;
        end else if (tick) begin
            case (step_q)
                STEP_0: begin
                    q_d    = 1'b1;
                    step_d = STEP_1;
                end
                STEP_1: begin
                    q_d    = 1'b1;
                    h_d    = 1'b1;
                    step_d = STEP_2;
                end
                STEP_2: begin
                    q_d    = 1'b1;
                    step_d = STEP_3;
                end
                STEP_3: begin
                    if (mode_q) begin
                        // 5-step mode: silent step
                        step_d = STEP_4;
                    end else begin
                        q_d     = 1'b1;
                        h_d     = 1'b1;
                        set_irq = 1'b1;
                        step_d  = STEP_0;
                    end
                end
                STEP_4: begin
                    q_d    = 1'b1;
                    h_d    = 1'b1;
                    step_d = STEP_0;
                end
                default: begin
                    step_d = STEP_0;
                end
            endcase
        end
    end

`ifdef FRAME_IRQ_EN
    logic inhibit_q;

    // IRQ inhibit bit, loaded on a config write
    always_ff @(posedge clk) begin
        if (rst) begin
            inhibit_q <= 1'b0;
        end else if (cfg_we) begin
            inhibit_q <= cfg_irq_inhibit;
        end
    end

    // Frame IRQ flag: set beats clear, so an ack on the set cycle is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_irq <= 1'b0;
        end else if (set_irq && !inhibit_q) begin
            frame_irq <= 1'b1;
        end else if (irq_ack || (cfg_we && cfg_irq_inhibit)) begin
            frame_irq <= 1'b0;
        end
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_ack, cfg_irq_inhibit, set_irq};
    assign frame_irq         = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer (CLKRATE=40, FRAMERATE=4, DIV=10).
// A timing model predicts {quarter_frame, half_frame, frame_irq, step} from
// the number of cycles since the last restart (reset or config write); the
// prediction is queued before each edge and popped after it.
module tb_apu_frame_sequencer;

    localparam int DIV = 10;
`ifdef FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_mode = 1'b0;
    logic       cfg_irq_inhibit = 1'b0;
    logic       irq_ack = 1'b0;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic [2:0] step;

    int errors = 0;
    int checks = 0;

    logic [5:0] exp_q[$];
    logic [5:0] exp_v;
    logic [5:0] act_v;

    // Model state: cycles since restart, mode, inhibit, irq, immediate pulse
    int m_t   = 0;
    bit m_mode = 1'b0;
    bit m_inh  = 1'b0;
    bit m_irq  = 1'b0;
    bit m_imm  = 1'b0;

    apu_frame_sequencer #(
        .CLKRATE  (40),
        .FRAMERATE(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_mode       (cfg_mode),
        .cfg_irq_inhibit(cfg_irq_inhibit),
        .irq_ack        (irq_ack),
        .quarter_frame  (quarter_frame),
        .half_frame     (half_frame),
        .frame_irq      (frame_irq),
        .step           (step)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current model state
    function automatic logic [5:0] model_out();
        int   n;
        int   s;
        logic q;
        logic h;
        n = m_mode ? 5 : 4;
        q = 1'b0;
        h = 1'b0;
        if (m_imm) begin
            q = 1'b1;
            h = 1'b1;
        end else if (m_t > 0 && (m_t % DIV) == 0) begin
            s = (m_t / DIV - 1) % n;
            q = !(m_mode && s == 3);
            h = (s == 1) || (s == 3 && !m_mode) || (s == 4);
        end
        return {q, h, m_irq, 3'((m_t / DIV) % n)};
    endfunction

    // Drive one cycle of inputs, advance the model, queue the prediction
    task automatic step_clk(input bit r, input bit we, input bit mode,
                            input bit inh, input bit ack);
        int n;
        int s;
        bit tick;
        rst             = r;
        cfg_we          = we;
        cfg_mode        = mode;
        cfg_irq_inhibit = inh;
        irq_ack         = ack;
        n    = m_mode ? 5 : 4;
        s    = (m_t / DIV) % n;
        tick = (m_t % DIV) == DIV - 1;
        if (r) begin
            m_t = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_imm = 0;
        end else if (we) begin
            m_t    = 0;
            m_mode = mode;
            m_imm  = mode;
            if (IRQ_EN && (inh || ack)) m_irq = 1'b0;
            if (IRQ_EN) m_inh = inh;
        end else begin
            m_imm = 1'b0;
            if (IRQ_EN && tick && !m_mode && s == 3 && !m_inh) m_irq = 1'b1;
            else if (IRQ_EN && ack) m_irq = 1'b0;
            m_t++;
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        rst = 0; cfg_we = 0; cfg_mode = 0; cfg_irq_inhibit = 0; irq_ack = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step_clk(1, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_sb got=%b exp=%b", act_v, exp_v);
            end
            checks++;
            if (act_v !== 6'b0) begin
                errors++;
                $display("FAIL reset_state got=%b exp=000000", act_v);
            end
        end
    endtask

    task automatic test_free_run_4step();
        int qn = 0;
        int hn = 0;
        for (int c = 0; c < 85; c++) begin
            step_clk(0, 0, 0, 0, c == 45);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL free_run cyc=%0d got=%b exp=%b", c + 1, act_v, exp_v);
            end
            qn += int'(quarter_frame);
            hn += int'(half_frame);
            if (c + 1 == 40 || c + 1 == 80) begin
                checks++;
                if (frame_irq !== IRQ_EN || quarter_frame !== 1'b1 || half_frame !== 1'b1) begin
                    errors++;
                    $display("FAIL irq_set cyc=%0d got q/h/irq=%b%b%b exp=11%b",
                             c + 1, quarter_frame, half_frame, frame_irq, IRQ_EN);
                end
            end
            if (c + 1 == 46) begin
                checks++;
                if (frame_irq !== 1'b0) begin
                    errors++;
                    $display("FAIL irq_ack got=%b exp=0", frame_irq);
                end
            end
            if (c + 1 == 30) begin
                checks++;
                if (step !== 3'd3) begin
                    errors++;
                    $display("FAIL step_at_30 got=%0d exp=3", step);
                end
            end
        end
        checks++;
        if (qn != 8 || hn != 4) begin
            errors++;
            $display("FAIL pulse_count got q=%0d h=%0d exp q=8 h=4", qn, hn);
        end
    endtask

    task automatic test_mode5();
        int irq_rises = 0;
        // clear any pending IRQ first so a new set would be visible
        step_clk(0, 0, 0, 0, 1);
        exp_v = exp_q.pop_front();
        step_clk(0, 1, 1, 0, 0);
        exp_v = exp_q.pop_front();
        act_v = {quarter_frame, half_frame, frame_irq, step};
        checks++;
        if (act_v !== exp_v || !quarter_frame || !half_frame) begin
            errors++;
            $display("FAIL mode5_immediate got=%b exp=%b", act_v, exp_v);
        end
        for (int c = 0; c < 110; c++) begin
            step_clk(0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL mode5 cyc=%0d got=%b exp=%b", c + 1, act_v, exp_v);
            end
            irq_rises += int'(frame_irq);
        end
        checks++;
        if (irq_rises != 0) begin
            errors++;
            $display("FAIL mode5_irq got=%0d high cycles exp=0", irq_rises);
        end
    endtask

    task automatic test_cfg_on_tick();
        // return to 4-step, then issue a mode-0 write exactly on a tick
        step_clk(0, 1, 0, 0, 0);
        exp_v = exp_q.pop_front();
        for (int k = 0; k < 3 * DIV && (m_t % DIV) != DIV - 1 || m_t < DIV; k++) begin
            step_clk(0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL tick_align got=%b exp=%b", act_v, exp_v);
            end
        end
        checks++;
        if ((m_t % DIV) != DIV - 1) begin
            errors++;
            $display("FAIL tick_align_timeout got=%0d exp=%0d", m_t % DIV, DIV - 1);
        end
        step_clk(0, 1, 0, 0, 0);
        exp_v = exp_q.pop_front();
        act_v = {quarter_frame, half_frame, frame_irq, step};
        checks++;
        if (act_v !== exp_v || quarter_frame !== 1'b0 || half_frame !== 1'b0 || step !== 3'd0) begin
            errors++;
            $display("FAIL cfg_on_tick got=%b exp=%b", act_v, exp_v);
        end
        for (int c = 0; c < DIV; c++) begin
            step_clk(0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL after_cfg_tick cyc=%0d got=%b exp=%b", c + 1, act_v, exp_v);
            end
        end
        checks++;
        if (quarter_frame !== 1'b1 || half_frame !== 1'b0) begin
            errors++;
            $display("FAIL first_q_after_cfg got q/h=%b%b exp=10", quarter_frame, half_frame);
        end
    endtask

    task automatic test_ack_on_set();
        // restart 4-step, run to the step-3 tick and ack on that cycle
        step_clk(0, 1, 0, 0, 1);
        exp_v = exp_q.pop_front();
        for (int c = 0; c < 4 * DIV; c++) begin
            step_clk(0, 0, 0, 0, m_t == 4 * DIV - 1);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL ack_on_set cyc=%0d got=%b exp=%b", c + 1, act_v, exp_v);
            end
        end
        checks++;
        if (frame_irq !== IRQ_EN) begin
            errors++;
            $display("FAIL ack_vs_set got=%b exp=%b", frame_irq, IRQ_EN);
        end
    endtask

    task automatic test_inhibit();
        int irq_high = 0;
        step_clk(0, 1, 0, 1, 0);
        exp_v = exp_q.pop_front();
        act_v = {quarter_frame, half_frame, frame_irq, step};
        checks++;
        if (act_v !== exp_v || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_clear got=%b exp=%b", act_v, exp_v);
        end
        for (int c = 0; c < 200; c++) begin
            step_clk(0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL inhibit_run cyc=%0d got=%b exp=%b", c + 1, act_v, exp_v);
            end
            irq_high += int'(frame_irq);
        end
        checks++;
        if (irq_high != 0) begin
            errors++;
            $display("FAIL inhibit_irq got=%0d high cycles exp=0", irq_high);
        end
    endtask

    task automatic test_back_to_back();
        // consecutive writes: each 5-step write pulses, the 4-step one does not
        for (int c = 0; c < 4; c++) begin
            step_clk(0, 1, c != 2, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v || quarter_frame !== (c != 2)) begin
                errors++;
                $display("FAIL back_to_back wr=%0d got=%b exp=%b", c, act_v, exp_v);
            end
        end
        for (int c = 0; c < 3 * DIV; c++) begin
            step_clk(0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL b2b_run cyc=%0d got=%b exp=%b", c + 1, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        // assert reset on a tick cycle: the pending strobe must be dropped
        for (int k = 0; k < 2 * DIV && (m_t % DIV) != DIV - 1; k++) begin
            step_clk(0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
        end
        step_clk(1, 0, 0, 0, 0);
        exp_v = exp_q.pop_front();
        act_v = {quarter_frame, half_frame, frame_irq, step};
        checks++;
        if (act_v !== 6'b0 || act_v !== exp_v) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=000000", act_v);
        end
        for (int c = 0; c < 2 * DIV; c++) begin
            step_clk(0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            act_v = {quarter_frame, half_frame, frame_irq, step};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", c + 1, act_v, exp_v);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_free_run_4step();
        test_mode5();
        test_cfg_on_tick();
        test_ack_on_set();
        test_inhibit();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
